// File: rtl/vga_timing_sequencer.sv
// VGA raster timing generator: pixel/line counters, sync and blanking decode,
// and a frame-synchronous display-mode update through a valid/ready handshake.
module vga_timing_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_mode,
  output logic       cfg_ready,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       frame_start,
  output logic [1:0] mode_active,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ACT = (SYNC_POL != 0);

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       wrap;
  logic       pending;
  logic       xfer;
  logic [1:0] pend_mode;

  function automatic logic sync_level(input logic [9:0] pos,
                                      input logic [9:0] first,
                                      input logic [9:0] last);
    return ((pos >= first) && (pos <= last)) ? SYNC_ACT : ~SYNC_ACT;
  endfunction

  function automatic logic visible(input logic [9:0] h, input logic [9:0] v);
    return (h < H_VIS) && (v < V_VIS);
  endfunction

  always_comb begin
    h_nxt = hpos + 10'd1;
    v_nxt = vpos;
    if (hpos == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vpos == V_LAST) ? '0 : vpos + 10'd1;
    end
  end

  assign wrap    = pix_en && (hpos == H_LAST) && (vpos == V_LAST);
  assign pending = ~cfg_ready;
  assign xfer    = cfg_valid && cfg_ready;

  // Raster counters and decode, taken from the next counter values so the
  // sync/blank outputs line up with hpos/vpos on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      display_on  <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= wrap;
      if (pix_en) begin
        hpos       <= h_nxt;
        vpos       <= v_nxt;
        hsync      <= sync_level(h_nxt, HS_FIRST, HS_LAST);
        vsync      <= sync_level(v_nxt, VS_FIRST, VS_LAST);
        display_on <= visible(h_nxt, v_nxt);
      end
      if (wrap) frame_count <= frame_count + 8'd1;
    end
  end

  // A mode captured on the wrap edge itself can only arrive while nothing is
  // pending, so it naturally waits for the following wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready   <= 1'b1;
      mode_active <= '0;
    end else if (wrap && pending) begin
      cfg_ready   <= 1'b1;
      mode_active <= pend_mode;
    end else if (xfer) begin
      cfg_ready   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) pend_mode <= cfg_mode;
  end

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Directed bench for vga_timing_sequencer: default horizontal timing, shortened
// vertical timing (10 lines, 2-line vsync) so whole frames stay short.
module tb_vga_timing_sequencer;

  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int FRAME    = 800 * 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic       cfg_ready;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       frame_start;
  logic [1:0] mode_active;
  logic [7:0] frame_count;

  int checks = 0;
  int failures = 0;

  vga_timing_sequencer #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .cfg_valid(cfg_valid),
    .cfg_mode(cfg_mode), .cfg_ready(cfg_ready), .hpos(hpos), .vpos(vpos),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .frame_start(frame_start), .mode_active(mode_active),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic exp_hs(input int h);
    return !(h >= 656 && h <= 751);
  endfunction

  function automatic logic exp_vs(input int v);
    return !(v >= 6 && v <= 7);
  endfunction

  function automatic logic exp_de(input int h, input int v);
    return (h < 640) && (v < 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_fs(input int bound, output int n, output int early_mode,
                           input logic [1:0] mode_before);
    n = 0;
    early_mode = 0;
    while (n < bound) begin
      step();
      n++;
      if (frame_start) break;
      if (mode_active !== mode_before) early_mode++;
    end
  endtask

  task automatic run_to_pos(input int h, input int v, input int bound, output logic found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (hpos == 10'(h) && vpos == 10'(v)) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hpos"}, 32'(hpos), 0);
    chk({tag, "_vpos"}, 32'(vpos), 0);
    chk({tag, "_fc"}, 32'(frame_count), 0);
    chk({tag, "_mode"}, 32'(mode_active), 0);
    chk({tag, "_ready"}, 32'(cfg_ready), 1);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_hsync"}, 32'(hsync), 1);
    chk({tag, "_vsync"}, 32'(vsync), 1);
    chk({tag, "_de"}, 32'(display_on), 1);
  endtask

  initial begin
    int hs_low, de_hi, first_hs, n, early, vs_low, fs_cnt, dec_err, exp_h;
    logic found;

    // Reset state
    repeat (3) step();
    chk_reset_vals("reset");

    // One full line from the reset position
    rst = 1'b0;
    pix_en = 1'b1;
    hs_low = 0; de_hi = 0; first_hs = -1; dec_err = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hsync) begin
        hs_low++;
        if (first_hs < 0) first_hs = int'(hpos);
      end
      if (display_on) de_hi++;
      if (hsync !== exp_hs(int'(hpos)) || display_on !== exp_de(int'(hpos), int'(vpos)))
        dec_err++;
      step();
      if (i == 0) chk("first_edge_hpos", 32'(hpos), 1);
    end
    chk("line_hsync_low", hs_low, 96);
    chk("line_hsync_first", first_hs, 656);
    chk("line_de_high", de_hi, 640);
    chk("line_decode", dec_err, 0);
    chk("line_end_hpos", 32'(hpos), 0);
    chk("line_end_vpos", 32'(vpos), 1);

    // First frame boundary
    run_to_fs(FRAME + 100, n, early, 2'd0);
    chk("fs1_period", n + 800, FRAME);
    chk("fs1_hpos", 32'(hpos), 0);
    chk("fs1_vpos", 32'(vpos), 0);
    chk("fs1_fc", 32'(frame_count), 1);

    // Full second frame
    vs_low = 0; fs_cnt = 0; dec_err = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (!vsync) vs_low++;
      if (frame_start) fs_cnt++;
      if (vsync !== exp_vs(int'(vpos)) || hsync !== exp_hs(int'(hpos)) ||
          display_on !== exp_de(int'(hpos), int'(vpos)))
        dec_err++;
    end
    chk("frame_vsync_low", vs_low, 1600);
    chk("frame_fs_count", fs_cnt, 1);
    chk("frame_fs_last", 32'(frame_start), 1);
    chk("frame_decode", dec_err, 0);
    chk("fs2_fc", 32'(frame_count), 2);

    // Enable toggling
    exp_h = 0;
    for (int i = 0; i < 6; i++) begin
      pix_en = (i % 2 == 0);
      step();
      if (pix_en) exp_h++;
      chk("tog_hpos", 32'(hpos), exp_h);
      chk("tog_vpos", 32'(vpos), 0);
      chk("tog_hsync", 32'(hsync), 32'(exp_hs(exp_h)));
      chk("tog_vsync", 32'(vsync), 32'(exp_vs(0)));
      chk("tog_de", 32'(display_on), 32'(exp_de(exp_h, 0)));
      chk("tog_fs", 32'(frame_start), 0);
      chk("tog_fc", 32'(frame_count), 2);
    end

    // Mid-frame mode offer, second offer ignored while pending
    pix_en = 1'b1;
    cfg_valid = 1'b1;
    cfg_mode = 2'd2;
    step();
    chk("cfg_ready_fall", 32'(cfg_ready), 0);
    chk("cfg_mode_hold", 32'(mode_active), 0);
    cfg_mode = 2'd3;
    repeat (3) step();
    cfg_valid = 1'b0;
    chk("cfg_ready_still", 32'(cfg_ready), 0);
    run_to_fs(FRAME + 100, n, early, 2'd0);
    chk("cfg_fs_seen", 32'(frame_start), 1);
    chk("cfg_no_early", early, 0);
    chk("cfg_mode_applied", 32'(mode_active), 2);
    chk("cfg_ready_back", 32'(cfg_ready), 1);
    chk("cfg_fc", 32'(frame_count), 3);

    // Transfer on the wrap edge is deferred one frame
    run_to_pos(799, 9, FRAME + 100, found);
    chk("same_found", 32'(found), 1);
    cfg_valid = 1'b1;
    cfg_mode = 2'd1;
    step();
    cfg_valid = 1'b0;
    chk("same_fs", 32'(frame_start), 1);
    chk("same_mode_kept", 32'(mode_active), 2);
    chk("same_ready", 32'(cfg_ready), 0);
    run_to_fs(FRAME + 100, n, early, 2'd2);
    chk("same_period", n, FRAME);
    chk("same_no_early", early, 0);
    chk("same_mode_next", 32'(mode_active), 1);
    chk("same_ready_next", 32'(cfg_ready), 1);

    // Async reset mid-frame with a mode pending
    cfg_valid = 1'b1;
    cfg_mode = 2'd3;
    step();
    cfg_valid = 1'b0;
    chk("rst_pending", 32'(cfg_ready), 0);
    run_to_pos(300, 2, FRAME + 100, found);
    chk("rst_found", 32'(found), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    step();
    chk_reset_vals("held_rst");
    rst = 1'b0;
    run_to_fs(FRAME + 100, n, early, 2'd0);
    chk("post_rst_period", n, FRAME);
    chk("post_rst_no_mode", early, 0);
    chk("post_rst_mode", 32'(mode_active), 0);
    chk("post_rst_fc", 32'(frame_count), 1);
    chk("post_rst_ready", 32'(cfg_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
